// File: rtl/piso_framed_if.sv
// Parallel-in / serial-out handshake bundle: upstream word offer plus serial-side status.
interface piso_framed_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_ready;
  logic                  sout;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output din_valid,
    output din,
    input  din_ready,
    input  sout,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  din_valid,
    input  din,
    output din_ready,
    output sout,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/piso_framed.sv
// Double-buffered parallel-to-serial shifter with optional start/stop framing.
//
// state | meaning
// IDLE  | line idle (sout=1), waiting for the holding register to fill
// START | driving the start bit (0)
// DATA  | driving DATA_WIDTH data bits, order set by MSB_FIRST
// STOP  | driving the stop bit (1)
module piso_framed #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0,
  parameter int FRAME_EN     = 1
) (
  input  logic           clk,
  input  logic           rst,
  piso_framed_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CYC_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_sout, w_sout_nxt;
  logic [CW-1:0]         r_cyc, w_cyc_nxt;
  logic [BW-1:0]         r_bit, w_bit_nxt;
  logic                  w_bit_end;
  logic                  w_frame_end;
  logic                  w_start;
  logic                  w_take_hold;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  // Cycle counter is a down-counter; a bit ends when it reaches zero.
  assign w_bit_end = (r_cyc == '0);

  // Next-state, next-bit and frame-boundary decode.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_sout_nxt  = r_sout;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_frame_end = 1'b0;
    w_start     = 1'b0;
    w_take_hold = 1'b0;

    case (r_state)
      IDLE: begin
        w_sout_nxt = 1'b1;
        w_start    = r_hold_full;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_sout_nxt  = first_bit(r_shift);
          w_shift_nxt = advance(r_shift);
          w_bit_nxt   = '0;
          w_cyc_nxt   = CYC_RELOAD;
        end else begin
          w_cyc_nxt = r_cyc - CW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == BIT_LAST) begin
            if (FRAME_EN != 0) begin
              w_state_nxt = STOP;
              w_sout_nxt  = 1'b1;
              w_cyc_nxt   = CYC_RELOAD;
            end else begin
              w_frame_end = 1'b1;
            end
          end else begin
            w_bit_nxt   = r_bit + BW'(1);
            w_sout_nxt  = first_bit(r_shift);
            w_shift_nxt = advance(r_shift);
            w_cyc_nxt   = CYC_RELOAD;
          end
        end else begin
          w_cyc_nxt = r_cyc - CW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_frame_end = 1'b1;
        end else begin
          w_cyc_nxt = r_cyc - CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A full holding register at frame end chains straight into the next frame.
    if (w_frame_end) begin
      if (r_hold_full) begin
        w_start = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_sout_nxt  = 1'b1;
      end
    end

    if (w_start) begin
      w_take_hold = 1'b1;
      w_cyc_nxt   = CYC_RELOAD;
      w_bit_nxt   = '0;
      if (FRAME_EN != 0) begin
        w_state_nxt = START;
        w_sout_nxt  = 1'b0;
        w_shift_nxt = r_hold;
      end else begin
        w_state_nxt = DATA;
        w_sout_nxt  = first_bit(r_hold);
        w_shift_nxt = advance(r_hold);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shifter, serial output and bit/cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_sout  <= 1'b1;
      r_cyc   <= '0;
      r_bit   <= '0;
    end else begin
      r_shift <= w_shift_nxt;
      r_sout  <= w_sout_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Holding register: drains into the shifter, refills only when it was empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_take_hold) begin
      r_hold_full <= 1'b0;
    end else if (bus.din_valid && !r_hold_full) begin
      r_hold      <= bus.din;
      r_hold_full <= 1'b1;
    end
  end

  assign bus.din_ready  = ~r_hold_full;
  assign bus.sout       = r_sout;
  assign bus.busy       = (r_state != IDLE) || r_hold_full;
  assign bus.frame_done = w_frame_end;

endmodule

// File: tb/tb_piso_framed.sv
// Bench for piso_framed: three configurations driven with directed and random words,
// compared cycle by cycle against a frame-level reference of the serial line.
module tb_piso_framed;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_framed_if #(.DATA_WIDTH(8)) bus0 ();
  piso_framed_if #(.DATA_WIDTH(8)) bus1 ();
  piso_framed_if #(.DATA_WIDTH(8)) bus2 ();

  // dut0: CPB=1 LSB framed; dut1: CPB=1 MSB unframed; dut2: CPB=4 LSB framed
  piso_framed #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0), .FRAME_EN(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  piso_framed #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1), .FRAME_EN(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  piso_framed #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(0), .FRAME_EN(1))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int p_cpb [3] = '{1, 1, 4};
  bit p_fe  [3] = '{1'b1, 1'b0, 1'b1};
  bit p_msb [3] = '{1'b0, 1'b1, 1'b0};

  logic [2:0] v_valid;
  logic [7:0] v_din [3];
  logic [2:0] o_sout, o_ready, o_busy, o_fd;

  assign bus0.din_valid = v_valid[0];
  assign bus1.din_valid = v_valid[1];
  assign bus2.din_valid = v_valid[2];
  assign bus0.din = v_din[0];
  assign bus1.din = v_din[1];
  assign bus2.din = v_din[2];
  assign o_sout  = {bus2.sout, bus1.sout, bus0.sout};
  assign o_ready = {bus2.din_ready, bus1.din_ready, bus0.din_ready};
  assign o_busy  = {bus2.busy, bus1.busy, bus0.busy};
  assign o_fd    = {bus2.frame_done, bus1.frame_done, bus0.frame_done};

  logic [7:0] wq [8];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers wq[0..n-1] back-to-back to dut k and checks the serial line against
  // the frame-level reference: one idle cycle after acceptance, then contiguous
  // frames with each bit held CPB cycles, then the idle level.
  task automatic run_stream(input int k, input int n, input bit noise, input bit rel);
    bit q_sout [$];
    bit q_fd [$];
    bit q_busy [$];
    bit fb [$];
    logic [7:0] w;
    logic acc;
    int fed;
    int j;
    int budget;

    q_sout.push_back(1'b1); q_fd.push_back(1'b0); q_busy.push_back(1'b1);
    for (int f = 0; f < n; f++) begin
      w = wq[f];
      fb.delete();
      if (p_fe[k]) fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(p_msb[k] ? w[7-i] : w[i]);
      if (p_fe[k]) fb.push_back(1'b1);
      for (int b = 0; b < fb.size(); b++) begin
        for (int r = 0; r < p_cpb[k]; r++) begin
          q_sout.push_back(fb[b]);
          q_fd.push_back((b == fb.size() - 1) && (r == p_cpb[k] - 1));
          q_busy.push_back(1'b1);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      q_sout.push_back(1'b1); q_fd.push_back(1'b0); q_busy.push_back(1'b0);
    end

    @(negedge clk);
    if (rel) rst = 1'b0;
    v_valid[k] = 1'b1;
    v_din[k] = wq[0];
    fed = 0;
    j = -1;
    budget = q_sout.size() + 20;
    for (int c = 0; c < budget && j < q_sout.size(); c++) begin
      acc = v_valid[k] && o_ready[k];
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        check($sformatf("dut%0d_ready_low_after_accept", k), o_ready[k], 0);
        fed++;
        if (j < 0) j = 0;
      end
      if (fed < n) begin
        v_valid[k] = 1'b1;
        v_din[k] = wq[fed];
      end else if (noise && !o_ready[k]) begin
        v_valid[k] = 1'b1;
        v_din[k] = 8'($urandom);
      end else begin
        v_valid[k] = 1'b0;
      end
      if (j >= 0) begin
        check($sformatf("dut%0d_sout_c%0d", k, j), o_sout[k], q_sout[j]);
        check($sformatf("dut%0d_frame_done_c%0d", k, j), o_fd[k], q_fd[j]);
        check($sformatf("dut%0d_busy_c%0d", k, j), o_busy[k], q_busy[j]);
        j++;
      end
    end
    v_valid[k] = 1'b0;
    check($sformatf("dut%0d_stream_complete", k), j, q_sout.size());
    check($sformatf("dut%0d_words_accepted", k), fed, n);
  endtask

  initial begin
    rst = 1'b1;
    v_valid = '0;
    for (int k = 0; k < 3; k++) v_din[k] = '0;
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_sout%0d", k), o_sout[k], 1);
      check($sformatf("rst_ready%0d", k), o_ready[k], 1);
      check($sformatf("rst_busy%0d", k), o_busy[k], 0);
      check($sformatf("rst_fd%0d", k), o_fd[k], 0);
    end
    repeat (2) @(negedge clk);

    // Framed LSB-first A5, reset released on the cycle the word is offered.
    wq[0] = 8'hA5;
    run_stream(0, 1, 1'b0, 1'b1);

    // Unframed MSB-first C3.
    wq[0] = 8'hC3;
    run_stream(1, 1, 1'b0, 1'b0);

    // Back-to-back words with spurious offers while the holding register is full.
    wq[0] = 8'h01; wq[1] = 8'h80; wq[2] = 8'h55;
    run_stream(0, 3, 1'b1, 1'b0);

    // Four clocks per bit.
    wq[0] = 8'hFF;
    run_stream(2, 1, 1'b0, 1'b0);

    // Random word streams on every configuration.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        int n;
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) wq[i] = 8'($urandom);
        run_stream(k, n, 1'b1, 1'b0);
      end
    end

    // Reset during data bit 5 with a second word waiting in the holding register.
    @(negedge clk);
    v_valid[0] = 1'b1; v_din[0] = 8'h1F;
    @(posedge clk);
    @(negedge clk);
    v_din[0] = 8'hE7;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    v_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_sout_bit5", o_sout[0], 0);
    check("pre_rst_busy", o_busy[0], 1);
    check("pre_rst_ready", o_ready[0], 0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_sout", o_sout[0], 1);
    check("async_rst_ready", o_ready[0], 1);
    check("async_rst_busy", o_busy[0], 0);
    check("async_rst_fd", o_fd[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_sout_c%0d", c), o_sout[0], 1);
      check($sformatf("post_rst_busy_c%0d", c), o_busy[0], 0);
      check($sformatf("post_rst_fd_c%0d", c), o_fd[0], 0);
    end

    // Word offered on the first edge after reset release is accepted normally.
    rst = 1'b1;
    wq[0] = 8'($urandom);
    run_stream(0, 1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_framed.md
PISO_FRAMED -- requirements
Module: piso_framed

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning parallel word width (>=2).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit (>=1).
REQ-003 SHALL have parameter MSB_FIRST, default 0, meaning 1 = shift MSB first, 0 = LSB first.
REQ-004 SHALL have parameter FRAME_EN, default 1, meaning 1 = wrap each word in start bit (0) and stop bit (1).
REQ-005 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port din_valid  input  1  upstream offers din.
REQ-008 SHALL have port din  input  DATA_WIDTH  parallel word; upstream holds it stable while din_valid=1 and din_ready=0.
REQ-009 SHALL have port din_ready  output  1  holding register empty; word accepted on an edge where din_valid=1 and din_ready=1.
REQ-010 SHALL have port sout  output  1  registered serial output; idle level 1.
REQ-011 SHALL have port busy  output  1  high while a frame is shifting or the holding register is full.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse in the final cycle of the final bit of each frame.

Function
REQ-013 SHALL contain a one-word holding register plus a shift register (double buffering); din_ready = holding register empty, registered.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; START and STOP are skipped when FRAME_EN=0.
REQ-015 SHALL, in IDLE with holding register full, move the word to the shifter on the next edge and enter START (FRAME_EN=1) or DATA (FRAME_EN=0).
REQ-016 SHALL give latency: word accepted at edge N while IDLE and empty -> first frame bit on sout after edge N+1.
REQ-017 SHALL hold each bit on sout exactly CLKS_PER_BIT cycles, counted by a cycle counter that restarts per bit.
REQ-018 SHALL emit DATA_WIDTH data bits in DATA, ordered per MSB_FIRST, tracked by a bit counter of width $clog2(DATA_WIDTH).
REQ-019 SHALL produce frame length DATA_WIDTH+2 bits (FRAME_EN=1) or DATA_WIDTH bits (FRAME_EN=0).
REQ-020 SHALL, at the end of a frame's last bit with holding register full, load the next word and start the next frame on the following edge with no idle bit (back-to-back).
REQ-021 SHALL, at the end of the last bit with holding register empty, return to IDLE and drive sout=1.
REQ-022 SHALL, when the holding register empties on the same edge a word is offered, not accept that word (din_ready was 0); acceptance occurs the next cycle.
REQ-023 SHALL ignore din while din_ready=0; din_valid=0 never alters state.
REQ-024 SHALL assert frame_done exactly once per frame, never for aborted frames.

Reset
REQ-025 SHALL, on rst=1, immediately (asynchronously) force state IDLE, sout=1, din_ready=1, busy=0, frame_done=0, holding register empty, counters 0.
REQ-026 SHALL, on reset mid-frame, discard both the shifting and held words; no partial frame resumes after release.
REQ-027 SHALL, on the first edge after rst deasserts, accept a valid word normally.

Verification
REQ-028 SHALL verify W=8, CPB=1, FRAME_EN=1, LSB first, din=8'hA5 -> sout 0,1,0,1,0,0,1,0,1,1 then 1; frame_done in the 10th bit cycle.
REQ-029 SHALL verify MSB_FIRST=1, FRAME_EN=0, din=8'hC3 -> sout 1,1,0,0,0,0,1,1; frame_done in the 8th cycle.
REQ-030 SHALL verify back-to-back 8'h01, 8'h80, 8'h55 with din_valid held -> 30 contiguous bits, no idle gap; din_ready=0 while the holding register is full; 3 frame_done pulses.
REQ-031 SHALL verify CPB=4, din=8'hFF -> each bit held 4 cycles; frame spans 40 cycles; busy high for all 40.
REQ-032 SHALL verify rst asserted during data bit 5 -> sout=1, din_ready=1, busy=0 without a clock edge; no frame_done.
REQ-033 SHALL verify din_valid pulsed while din_ready=0 -> word not captured; output stream unchanged.
